mem_program_loader: RTL and testbench

// - Write-side counterpart to the core's instruction fetch path: streams a program image into mem before the core runs.
// - Accepts a byte stream (valid/ready) and packs it into 32-bit little-endian words.
// - Writes the words through the mem write port, holding the core in reset until the image has loaded and its checksum verifies.
// - In the processor top it sits beside inst_data_arbiter. out_mem_sel muxes mem's port between the loader and the arbiter.

---
 rtl/mem_program_loader_pkg.sv | 11 +
 rtl/mem_program_loader_if.sv | 28 ++
 rtl/mem_program_loader_byte_packer.sv | 40 ++++
 rtl/mem_program_loader.sv | 113 +++++++++++
 tb/tb_mem_program_loader.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_program_loader_pkg.sv
// Shared types and constants for the program-image loader.
package mem_program_loader_pkg;

    typedef enum logic [2:0] {LEN, DATA, WRITE, CHK, DONE, ERR} loader_state_t;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = 32;
    localparam logic [3:0]  BYTE_EN_ALL    = 4'hF;

endpackage

// File: rtl/mem_program_loader_if.sv
// Byte stream in, mem write port out; master = loader, slave = source/mem side.
interface mem_program_loader_if #(
    parameter int unsigned MEM_ADDR_WD = 10
);
    import mem_program_loader_pkg::*;

    logic                   in_valid;
    logic [BYTE_W-1:0]      in_data;
    logic                   in_ready;
    logic                   out_mem_sel;
    logic [MEM_ADDR_WD-1:0] out_mem_addr;
    logic                   out_mem_re_web;
    logic [WORD_W-1:0]      out_mem_write_data;
    logic [3:0]             out_mem_byte_en;

    modport master (
        input  in_valid, in_data,
        output in_ready, out_mem_sel, out_mem_addr, out_mem_re_web,
               out_mem_write_data, out_mem_byte_en
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, out_mem_sel, out_mem_addr, out_mem_re_web,
               out_mem_write_data, out_mem_byte_en
    );

endinterface

// File: rtl/mem_program_loader_byte_packer.sv
// Packs accepted bytes into a 32-bit little-endian word; flags the 4th byte.
module mem_program_loader_byte_packer
    import mem_program_loader_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              accept_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WORD_W-1:0] word_c_o,
    output logic              word_full_c_o
);

    localparam int unsigned CNT_W = $clog2(BYTES_PER_WORD);

    logic [CNT_W-1:0]  cnt_q;
    logic [WORD_W-1:0] word_q;

    // Current word with the incoming byte inserted at its lane.
    always_comb begin
        word_c_o = word_q;
        for (int k = 0; k < BYTES_PER_WORD; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                word_c_o[k*BYTE_W +: BYTE_W] = byte_i;
            end
        end
        word_full_c_o = accept_i && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));
    end

    // Byte counter and partial word; cleared once a word completes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else if (accept_i) begin
            cnt_q  <= cnt_q + CNT_W'(1);
            word_q <= word_full_c_o ? '0 : word_c_o;
        end
    end

endmodule

// File: rtl/mem_program_loader.sv
// Streams a length-prefixed, XOR-checksummed program image into mem and
// holds the core in reset until the image has loaded and verified.
module mem_program_loader
    import mem_program_loader_pkg::*;
#(
    parameter int unsigned MEM_ADDR_WD = 10,
    parameter int unsigned BASE_WORD   = 0,
    parameter int unsigned MAX_WORDS   = 2**MEM_ADDR_WD
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    mem_program_loader_if.master bus,
    output logic                 core_rst,
    output logic                 done,
    output logic                 err
);

    loader_state_t          state_q, state_d;
    logic [MEM_ADDR_WD-1:0] idx_q, last_idx_q, addr_q;
    logic [BYTE_W-1:0]      acc_q;
    logic [WORD_W-1:0]      wdata_q;
    logic [3:0]             byte_en_q;
    logic                   in_ready_q, sel_q, re_web_q, core_rst_q, done_q, err_q;

    logic                   handshake_c, pack_accept_c, pack_full_c;
    logic [WORD_W-1:0]      pack_word_c;

    assign handshake_c   = bus.in_valid & in_ready_q;
    assign pack_accept_c = handshake_c && ((state_q == LEN) || (state_q == DATA));

    mem_program_loader_byte_packer u_packer (
        .clk_i         (i_clk),
        .rst_i         (i_rst),
        .accept_i      (pack_accept_c),
        .byte_i        (bus.in_data),
        .word_c_o      (pack_word_c),
        .word_full_c_o (pack_full_c)
    );

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LEN: begin
                if (pack_full_c) begin
                    if (pack_word_c == '0)                  state_d = CHK;
                    else if (pack_word_c > 32'(MAX_WORDS)) state_d = ERR;
                    else                                    state_d = DATA;
                end
            end
            DATA:    if (pack_full_c) state_d = WRITE;
            WRITE:   state_d = (idx_q == last_idx_q) ? CHK : DATA;
            CHK:     if (handshake_c) state_d = (bus.in_data == acc_q) ? DONE : ERR;
            DONE:    state_d = DONE;
            ERR:     state_d = ERR;
            default: state_d = LEN;
        endcase
    end

    // State, datapath and registered outputs decoded from the next state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= LEN;
            idx_q      <= '0;
            last_idx_q <= '0;
            acc_q      <= '0;
            addr_q     <= MEM_ADDR_WD'(BASE_WORD);
            wdata_q    <= '0;
            byte_en_q  <= '0;
            in_ready_q <= 1'b0;
            sel_q      <= 1'b1;
            re_web_q   <= 1'b1;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d == LEN) || (state_d == DATA) ||
                          (state_d == CHK) || (state_d == ERR);
            sel_q      <= (state_d != DONE);
            core_rst_q <= (state_d != DONE);
            done_q     <= (state_d == DONE);
            err_q      <= (state_d == ERR);
            re_web_q   <= (state_d != WRITE);
            byte_en_q  <= (state_d == WRITE) ? BYTE_EN_ALL : 4'h0;

            if ((state_q == LEN) && pack_full_c) begin
                last_idx_q <= MEM_ADDR_WD'(pack_word_c - 32'd1);
            end
            if ((state_q == DATA) && handshake_c) begin
                acc_q <= acc_q ^ bus.in_data;
            end
            if ((state_q == DATA) && pack_full_c) begin
                addr_q  <= MEM_ADDR_WD'(BASE_WORD) + idx_q;
                wdata_q <= pack_word_c;
            end
            if (state_q == WRITE) begin
                idx_q <= idx_q + MEM_ADDR_WD'(1);
            end
        end
    end

    assign bus.in_ready           = in_ready_q;
    assign bus.out_mem_sel        = sel_q;
    assign bus.out_mem_addr       = addr_q;
    assign bus.out_mem_re_web     = re_web_q;
    assign bus.out_mem_write_data = wdata_q;
    assign bus.out_mem_byte_en    = byte_en_q;
    assign core_rst               = core_rst_q;
    assign done                   = done_q;
    assign err                    = err_q;

endmodule

// File: tb/tb_mem_program_loader.sv
// Bench for mem_program_loader: two instances (base 0 and base at the top
// of the address space), a mem model and a write scoreboard.
module tb_mem_program_loader;
    import mem_program_loader_pkg::*;

    localparam int unsigned AW     = 10;
    localparam int unsigned BASE_B = 2**AW - 1;
    localparam int unsigned MAXW   = 2**AW;

    typedef struct {
        bit            which;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_program_loader_if #(.MEM_ADDR_WD(AW)) ifa ();
    mem_program_loader_if #(.MEM_ADDR_WD(AW)) ifb ();
    logic core_rst_a, done_a, err_a, core_rst_b, done_b, err_b;

    mem_program_loader #(.MEM_ADDR_WD(AW), .BASE_WORD(0)) dut_a (
        .i_clk(clk), .i_rst(rst), .bus(ifa),
        .core_rst(core_rst_a), .done(done_a), .err(err_a)
    );

    mem_program_loader #(.MEM_ADDR_WD(AW), .BASE_WORD(BASE_B)) dut_b (
        .i_clk(clk), .i_rst(rst), .bus(ifb),
        .core_rst(core_rst_b), .done(done_b), .err(err_b)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          wr_cnt_a = 0;
    int          wr_cnt_b = 0;
    int          gap_max = 0;
    wr_t         exp_q[$];
    logic [31:0] img[$];
    logic [31:0] mem_a [0:MAXW-1];
    logic [31:0] mem_b [0:MAXW-1];

    // Write monitor: model mem and pop the scoreboard on every write cycle.
    logic          m_wr, m_rdy;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_data;
    logic [3:0]    m_be;
    wr_t           m_exp;
    always @(negedge clk) begin
        for (int w = 0; w < 2; w++) begin
            m_wr   = (w == 0) ? (ifa.out_mem_sel && !ifa.out_mem_re_web)
                              : (ifb.out_mem_sel && !ifb.out_mem_re_web);
            m_addr = (w == 0) ? ifa.out_mem_addr : ifb.out_mem_addr;
            m_data = (w == 0) ? ifa.out_mem_write_data : ifb.out_mem_write_data;
            m_be   = (w == 0) ? ifa.out_mem_byte_en : ifb.out_mem_byte_en;
            m_rdy  = (w == 0) ? ifa.in_ready : ifb.in_ready;
            if (!rst && m_wr) begin
                if (w == 0) begin wr_cnt_a++; mem_a[m_addr] = m_data; end
                else        begin wr_cnt_b++; mem_b[m_addr] = m_data; end
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_write dut=%0d addr=%0h data=%08h required no write", w, m_addr, m_data);
                end else begin
                    m_exp = exp_q.pop_front();
                    if (m_exp.which !== w[0] || m_exp.addr !== m_addr || m_exp.data !== m_data ||
                        m_be !== BYTE_EN_ALL || m_rdy !== 1'b0) begin
                        n_bad++;
                        $display("FAIL mem_write got dut=%0d addr=%0h data=%08h be=%h rdy=%b required dut=%0d addr=%0h data=%08h be=f rdy=0",
                                 w, m_addr, m_data, m_be, m_rdy, m_exp.which, m_exp.addr, m_exp.data);
                    end
                end
            end
        end
    end

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One byte handshake; returns on the negedge after the accepting posedge.
    task automatic send_byte(input bit which, input logic [7:0] b);
        int budget;
        int n;
        if (gap_max > 0) begin
            n = $urandom_range(gap_max, 0);
            repeat (n) @(negedge clk);
        end
        if (which) begin ifb.in_valid = 1'b1; ifb.in_data = b; end
        else       begin ifa.in_valid = 1'b1; ifa.in_data = b; end
        budget = 0;
        while (!(which ? ifb.in_ready : ifa.in_ready) && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 50) begin
            n_cmp++; n_bad++;
            $display("FAIL handshake_timeout dut=%0d in_ready=0 required 1 within 50 cycles", which);
        end
        @(negedge clk);
        ifa.in_valid = 1'b0;
        ifb.in_valid = 1'b0;
    endtask

    task automatic send_word(input bit which, input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(which, w[8*k +: 8]);
    endtask

    // Header plus all words of img; returns the XOR of the data bytes.
    task automatic send_payload(input bit which, output logic [7:0] x);
        int unsigned base;
        base = which ? BASE_B : 0;
        x = 8'h00;
        send_word(which, 32'(img.size()));
        for (int i = 0; i < img.size(); i++) begin
            for (int k = 0; k < 4; k++) x ^= img[i][8*k +: 8];
            exp_q.push_back('{which, AW'(base + 32'(i)), img[i]});
            send_word(which, img[i]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({ifa.in_ready, ifa.out_mem_sel, ifa.out_mem_re_web, ifa.out_mem_byte_en,
             core_rst_a, done_a, err_a} !== {1'b0, 1'b1, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_ctrl rdy=%b sel=%b rew=%b be=%h crst=%b done=%b err=%b required 0 1 1 0 1 0 0",
                     ifa.in_ready, ifa.out_mem_sel, ifa.out_mem_re_web, ifa.out_mem_byte_en, core_rst_a, done_a, err_a);
        end
        n_cmp++;
        if (ifa.out_mem_addr !== AW'(0) || ifa.out_mem_write_data !== 32'h0 || ifb.out_mem_addr !== AW'(BASE_B)) begin
            n_bad++;
            $display("FAIL reset_addr a=%0h wd=%08h b=%0h required 0 00000000 %0h",
                     ifa.out_mem_addr, ifa.out_mem_write_data, ifb.out_mem_addr, BASE_B);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ifa.in_ready !== 1'b1 || ifb.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_after_reset a=%b b=%b required 1 1", ifa.in_ready, ifb.in_ready);
        end
    endtask

    task automatic test_two_words();
        logic [7:0] x;
        int w0;
        apply_reset();
        w0 = wr_cnt_a;
        img = '{32'h44332211, 32'hDDCCBBAA};
        send_payload(1'b0, x);
        n_cmp++;
        if (done_a !== 1'b0 || core_rst_a !== 1'b1) begin
            n_bad++;
            $display("FAIL two_words_pre_chk done=%b crst=%b required 0 1", done_a, core_rst_a);
        end
        send_byte(1'b0, x);
        n_cmp++;
        if ({done_a, err_a, core_rst_a, ifa.out_mem_sel, ifa.in_ready} !== 5'b10000) begin
            n_bad++;
            $display("FAIL two_words_done done=%b err=%b crst=%b sel=%b rdy=%b required 1 0 0 0 0",
                     done_a, err_a, core_rst_a, ifa.out_mem_sel, ifa.in_ready);
        end
        n_cmp++;
        if (mem_a[0] !== 32'h44332211 || mem_a[1] !== 32'hDDCCBBAA || wr_cnt_a - w0 != 2 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL two_words_mem m0=%08h m1=%08h writes=%0d pending=%0d required 44332211 ddccbbaa 2 0",
                     mem_a[0], mem_a[1], wr_cnt_a - w0, exp_q.size());
        end
    endtask

    task automatic test_zero_len();
        logic [7:0] x;
        int w0;
        apply_reset();
        w0 = wr_cnt_a;
        img.delete();
        send_payload(1'b0, x);
        send_byte(1'b0, 8'h00);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (done_a !== 1'b1 || err_a !== 1'b0 || core_rst_a !== 1'b0 || wr_cnt_a != w0) begin
            n_bad++;
            $display("FAIL zero_len done=%b err=%b crst=%b writes=%0d required 1 0 0 0",
                     done_a, err_a, core_rst_a, wr_cnt_a - w0);
        end
    endtask

    task automatic test_bad_checksum();
        logic [7:0] x;
        apply_reset();
        mem_a[0] = 32'h0;
        img = '{32'h04030201};
        send_payload(1'b0, x);
        send_byte(1'b0, 8'hFF);
        n_cmp++;
        if ({err_a, done_a, core_rst_a, ifa.out_mem_sel, ifa.in_ready} !== 5'b10111) begin
            n_bad++;
            $display("FAIL bad_chk err=%b done=%b crst=%b sel=%b rdy=%b required 1 0 1 1 1",
                     err_a, done_a, core_rst_a, ifa.out_mem_sel, ifa.in_ready);
        end
        n_cmp++;
        if (mem_a[0] !== 32'h04030201 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL bad_chk_mem m0=%08h pending=%0d required 04030201 0", mem_a[0], exp_q.size());
        end
    endtask

    task automatic test_oversize();
        int w0;
        apply_reset();
        w0 = wr_cnt_a;
        send_word(1'b0, 32'(MAXW));
        n_cmp++;
        if (err_a !== 1'b0 || ifa.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL max_words_legal err=%b rdy=%b required 0 1", err_a, ifa.in_ready);
        end
        apply_reset();
        send_word(1'b0, 32'(MAXW + 1));
        n_cmp++;
        if (err_a !== 1'b1 || done_a !== 1'b0) begin
            n_bad++;
            $display("FAIL oversize_err err=%b done=%b required 1 0", err_a, done_a);
        end
        for (int i = 0; i < 8; i++) send_byte(1'b0, 8'(i));
        n_cmp++;
        if (ifa.in_ready !== 1'b1 || err_a !== 1'b1 || wr_cnt_a != w0) begin
            n_bad++;
            $display("FAIL oversize_drain rdy=%b err=%b writes=%0d required 1 1 0",
                     ifa.in_ready, err_a, wr_cnt_a - w0);
        end
    endtask

    task automatic test_gaps();
        logic [7:0] x;
        int w0;
        img = '{$urandom, $urandom, $urandom};
        for (int pass = 0; pass < 2; pass++) begin
            apply_reset();
            for (int i = 0; i < 3; i++) mem_a[i] = 32'h0;
            gap_max = (pass == 0) ? 0 : 3;
            w0 = wr_cnt_a;
            send_payload(1'b0, x);
            send_byte(1'b0, x);
            gap_max = 0;
            n_cmp++;
            if (mem_a[0] !== img[0] || mem_a[1] !== img[1] || mem_a[2] !== img[2] ||
                wr_cnt_a - w0 != 3 || done_a !== 1'b1) begin
                n_bad++;
                $display("FAIL gaps_pass%0d m=%08h %08h %08h writes=%0d done=%b required %08h %08h %08h 3 1",
                         pass, mem_a[0], mem_a[1], mem_a[2], wr_cnt_a - w0, done_a, img[0], img[1], img[2]);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] x;
        int w0;
        apply_reset();
        mem_a[0] = 32'h0;
        w0 = wr_cnt_a;
        send_word(1'b0, 32'd1);
        send_byte(1'b0, 8'h55);
        send_byte(1'b0, 8'h66);
        apply_reset();
        img = '{32'hA1B2C3D4};
        send_payload(1'b0, x);
        send_byte(1'b0, x);
        n_cmp++;
        if (mem_a[0] !== 32'hA1B2C3D4 || wr_cnt_a - w0 != 1 || done_a !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_load m0=%08h writes=%0d done=%b required a1b2c3d4 1 1",
                     mem_a[0], wr_cnt_a - w0, done_a);
        end
    endtask

    task automatic test_addr_wrap();
        logic [7:0] x;
        int w0;
        apply_reset();
        w0 = wr_cnt_b;
        img = '{32'hCAFEF00D, 32'h12345678};
        send_payload(1'b1, x);
        send_byte(1'b1, x);
        n_cmp++;
        if (mem_b[BASE_B] !== 32'hCAFEF00D || mem_b[0] !== 32'h12345678 ||
            wr_cnt_b - w0 != 2 || done_b !== 1'b1 || err_b !== 1'b0) begin
            n_bad++;
            $display("FAIL addr_wrap top=%08h m0=%08h writes=%0d done=%b err=%b required cafef00d 12345678 2 1 0",
                     mem_b[BASE_B], mem_b[0], wr_cnt_b - w0, done_b, err_b);
        end
    endtask

    initial begin
        rst = 1'b1;
        ifa.in_valid = 1'b0; ifa.in_data = 8'h00;
        ifb.in_valid = 1'b0; ifb.in_data = 8'h00;
        test_reset();
        test_two_words();
        test_zero_len();
        test_bad_checksum();
        test_oversize();
        test_gaps();
        test_reset_mid_load();
        test_addr_wrap();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_pending left=%0d required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog sim time exceeded required completion");
        $fatal(1, "watchdog");
    end

endmodule
